// File: rtl/rs_enc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs_enc_ctrl                                                  |
// | Description : Streaming systematic RS(255-style) encoder, GF(2^8) 0x11D,   |
// |               6 parity symbols. RS_ENC_SHORTEN_EN adds runtime msg_len.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rs_enc_ctrl #(
    parameter int MSG_LEN = 249
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
`ifdef RS_ENC_SHORTEN_EN
    input  logic [7:0] msg_len,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_parity,
    output logic       out_last
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_data = 2'd1;
    localparam logic [1:0] c_st_par  = 2'd2;

    localparam logic [7:0] c_msg_len = 8'(MSG_LEN);
    localparam logic [7:0] c_len_max = 8'd249;
    localparam logic [2:0] c_par_end = 3'd5;

    // Index i holds generator coefficient g_i (g0 = 0x75 ... g5 = 0x7E).
    localparam logic [5:0][7:0] c_gen = {8'h7E, 8'h04, 8'h9E, 8'h1C, 8'h31, 8'h75};

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] v_acc;
        logic [7:0] v_sh;
        v_acc = 8'h00;
        v_sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) v_acc = v_acc ^ v_sh;
            v_sh = {v_sh[6:0], 1'b0} ^ (v_sh[7] ? 8'h1D : 8'h00);
        end
        return v_acc;
    endfunction

    logic [1:0]       r_state;
    logic [7:0]       r_sym_cnt;
    logic [2:0]       r_par_cnt;
    logic [7:0]       r_lfsr [6];
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_out_parity;
    logic             r_out_last;

    logic             w_free;
    logic             w_accept;
    logic [7:0]       w_fb;
    logic [5:0][7:0]  w_prod;
    logic [7:0]       w_cnt_next;
    logic [7:0]       w_len_first;
    logic [7:0]       w_len_data;

    assign w_free     = !r_out_valid || out_ready;
    assign in_ready   = (r_state != c_st_par) && w_free;
    assign w_accept   = in_valid && in_ready;
    assign w_fb       = in_data ^ r_lfsr[5];
    assign w_cnt_next = r_sym_cnt + 8'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_gmul
            assign w_prod[gi] = gf_mul(w_fb, c_gen[gi]);
        end
    endgenerate

`ifdef RS_ENC_SHORTEN_EN
    logic [7:0] r_len;

    // Out-of-range runtime lengths fall back to the configured length.
    assign w_len_first = ((msg_len == 8'd0) || (msg_len > c_len_max)) ? c_msg_len : msg_len;
    assign w_len_data  = r_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= c_msg_len;
        end else if (w_accept && (r_state == c_st_idle)) begin
            r_len <= w_len_first;
        end
    end
`else
    assign w_len_first = c_msg_len;
    assign w_len_data  = c_msg_len;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_sym_cnt    <= 8'd0;
            r_par_cnt    <= 3'd0;
            for (int i = 0; i < 6; i++) r_lfsr[i] <= 8'h00;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_parity <= 1'b0;
            r_out_last   <= 1'b0;
        end else if (w_accept) begin
            r_lfsr[0] <= w_prod[0];
            for (int i = 1; i < 6; i++) r_lfsr[i] <= r_lfsr[i-1] ^ w_prod[i];
            r_out_valid  <= 1'b1;
            r_out_data   <= in_data;
            r_out_parity <= 1'b0;
            r_out_last   <= 1'b0;
            if (r_state == c_st_idle) begin
                r_sym_cnt <= 8'd1;
                r_state   <= (w_len_first == 8'd1) ? c_st_par : c_st_data;
            end else begin
                r_sym_cnt <= w_cnt_next;
                if (w_cnt_next == w_len_data) r_state <= c_st_par;
            end
        end else if ((r_state == c_st_par) && w_free) begin
            // Drain the remainder highest degree first, zero-filling behind it.
            r_out_valid  <= 1'b1;
            r_out_data   <= r_lfsr[5];
            r_out_parity <= 1'b1;
            r_out_last   <= (r_par_cnt == c_par_end);
            r_lfsr[0]    <= 8'h00;
            for (int i = 1; i < 6; i++) r_lfsr[i] <= r_lfsr[i-1];
            if (r_par_cnt == c_par_end) begin
                r_par_cnt <= 3'd0;
                r_sym_cnt <= 8'd0;
                r_state   <= c_st_idle;
            end else begin
                r_par_cnt <= r_par_cnt + 3'd1;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_parity = r_out_parity;
    assign out_last   = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_rs_enc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rs_enc_ctrl                                               |
// | Description : Bench for rs_enc_ctrl; reference is polynomial long division.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rs_enc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_parity;
    logic       out_last;
`ifdef RS_ENC_SHORTEN_EN
    logic [7:0] msg_len = 8'h00;
`endif

    int n_err = 0;
    int n_chk = 0;

    logic [7:0]  gen [6] = '{8'h75, 8'h31, 8'h1C, 8'h9E, 8'h04, 8'h7E};
    logic [7:0]  cw_msg [$];
    logic [15:0] stim_q [$];
    logic [9:0]  exp_q [$];
    logic [9:0]  obs_q [$];
    int          r_span, r_stall, r_viol;

    always #5 clk = ~clk;

    rs_enc_ctrl #(.MSG_LEN(249)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
`ifdef RS_ENC_SHORTEN_EN
        .msg_len    (msg_len),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_last   (out_last)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    // Remainder of m(x)*x^6 divided by the monic generator, by long division.
    task automatic push_cw(input logic [7:0] lv);
        logic [7:0] b [$];
        logic [7:0] c;
        int n;
        n = cw_msg.size();
        b = cw_msg;
        for (int k = 0; k < 6; k++) b.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            c = b[i];
            for (int j = 1; j <= 6; j++) b[i+j] = b[i+j] ^ gmul(c, gen[6-j]);
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({2'b00, cw_msg[i]});
            stim_q.push_back({lv, cw_msg[i]});
        end
        for (int k = 0; k < 6; k++) exp_q.push_back({(k == 5), 1'b1, b[n+k]});
    endtask

    task automatic fill_msg(input int n, input bit rnd);
        cw_msg.delete();
        for (int i = 0; i < n; i++) cw_msg.push_back(rnd ? 8'($urandom) : 8'h00);
    endtask

    // Drives stim_q and collects handshaken outputs into obs_q; does no checking.
    task automatic run_stream(input int rdy_pct);
        int cyc, first, last;
        logic hold;
        logic [9:0] held;
        cyc = 0; first = -1; last = -1; hold = 1'b0; held = '0;
        r_stall = 0; r_viol = 0;
        obs_q.delete();
        while (obs_q.size() < exp_q.size() && cyc < 6000) begin
            @(posedge clk); #1;
            in_valid = (stim_q.size() > 0);
            in_data  = in_valid ? stim_q[0][7:0] : 8'h00;
`ifdef RS_ENC_SHORTEN_EN
            msg_len  = in_valid ? stim_q[0][15:8] : 8'h00;
`endif
            out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            cyc++;
            if (hold && ({out_last, out_parity, out_data} !== held)) r_viol++;
            if (hold && !out_valid) r_viol++;
            hold = out_valid && !out_ready;
            held = {out_last, out_parity, out_data};
            if (!in_ready) r_stall++;
            if (out_valid && first < 0) first = cyc;
            if (out_valid && out_ready) begin
                obs_q.push_back(held);
                last = cyc;
            end
            if (in_valid && in_ready) void'(stim_q.pop_front());
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        r_span = (first < 0 || last < 0) ? 0 : last - first + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", out_data); end
        n_chk++; if (out_parity !== 1'b0) begin n_err++; $display("FAIL rst_parity: got %b want 0", out_parity); end
        n_chk++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b want 0", out_last); end
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_msg();
        exp_q.delete(); stim_q.delete();
        fill_msg(249, 1'b0);
        push_cw(8'd0);
        run_stream(100);
        n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL zero_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL zero_sym[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_chk++; if (obs_q.size() == 255 && obs_q[254] !== 10'h300) begin n_err++; $display("FAIL zero_last: got %h want 300", obs_q[254]); end
        n_chk++; if (r_span != 255) begin n_err++; $display("FAIL zero_span: got %0d want 255", r_span); end
        n_chk++; if (r_stall != 6) begin n_err++; $display("FAIL zero_stall: got %0d want 6", r_stall); end
    endtask

    task automatic test_single_symbol();
        logic [7:0] par1 [6];
        logic [7:0] par2 [6];
        int npar;
        par1 = '{8'h7E, 8'h04, 8'h9E, 8'h1C, 8'h31, 8'h75};
        par2 = '{8'hFC, 8'h08, 8'h21, 8'h38, 8'h62, 8'hEA};
        for (int t = 0; t < 2; t++) begin
            exp_q.delete(); stim_q.delete();
            fill_msg(248, 1'b0);
            cw_msg.push_back(t == 0 ? 8'h01 : 8'h02);
            push_cw(8'd0);
            run_stream(100);
            n_chk++; if (obs_q.size() != 255) begin n_err++; $display("FAIL single%0d_count: got %0d want 255", t, obs_q.size()); end
            npar = 0;
            for (int i = 0; i < obs_q.size(); i++) begin
                if (obs_q[i][8]) npar++;
                n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single%0d_sym[%0d]: got %h want %h", t, i, obs_q[i], exp_q[i]); end
            end
            n_chk++; if (npar != 6) begin n_err++; $display("FAIL single%0d_npar: got %0d want 6", t, npar); end
            for (int k = 0; k < 6 && obs_q.size() == 255; k++) begin
                n_chk++;
                if (obs_q[249+k] !== {(k == 5), 1'b1, (t == 0 ? par1[k] : par2[k])}) begin
                    n_err++;
                    $display("FAIL single%0d_par[%0d]: got %h want %h", t, k, obs_q[249+k], {(k == 5), 1'b1, (t == 0 ? par1[k] : par2[k])});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        exp_q.delete(); stim_q.delete();
        for (int c = 0; c < 2; c++) begin
            fill_msg(249, 1'b1);
            push_cw(8'd0);
        end
        run_stream(50);
        n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_sym[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_chk++; if (r_viol != 0) begin n_err++; $display("FAIL bp_stable: got %0d violations want 0", r_viol); end
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); stim_q.delete();
        for (int c = 0; c < 3; c++) begin
            fill_msg(249, 1'b1);
            push_cw(8'd0);
        end
        run_stream(100);
        n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_sym[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_chk++; if (r_span != 765) begin n_err++; $display("FAIL b2b_span: got %0d want 765", r_span); end
        n_chk++; if (r_stall != 18) begin n_err++; $display("FAIL b2b_stall: got %0d want 18", r_stall); end
    endtask

    task automatic test_reset_mid();
        exp_q.delete(); stim_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 8'($urandom) | 8'h01;
        end
        @(posedge clk); #2;
        n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== 8'h00) begin n_err++; $display("FAIL mid_data: got %h want 00", out_data); end
        n_chk++; if ({out_parity, out_last} !== 2'b00) begin n_err++; $display("FAIL mid_flags: got %b want 00", {out_parity, out_last}); end
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fill_msg(249, 1'b1);
        push_cw(8'd0);
        run_stream(100);
        n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mid_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_sym[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

`ifdef RS_ENC_SHORTEN_EN
    task automatic test_shorten();
        logic [7:0] want1 [7];
        int lastpos [$];
        want1 = '{8'h01, 8'h7E, 8'h04, 8'h9E, 8'h1C, 8'h31, 8'h75};
        exp_q.delete(); stim_q.delete();
        cw_msg.delete(); cw_msg.push_back(8'h01); push_cw(8'd1);
        fill_msg(249, 1'b1); push_cw(8'd0);
        fill_msg(5, 1'b1);   push_cw(8'd5);
        fill_msg(249, 1'b1); push_cw(8'd250);
        run_stream(100);
        n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL sh_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sh_sym[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
            if (obs_q[i][9]) lastpos.push_back(i);
        end
        for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
            n_chk++; if (obs_q[i][7:0] !== want1[i]) begin n_err++; $display("FAIL sh_len1[%0d]: got %h want %h", i, obs_q[i][7:0], want1[i]); end
        end
        n_chk++; if (lastpos.size() < 2 || lastpos[1] != 7 + 255 - 1) begin n_err++; $display("FAIL sh_len0_pos: got %0d want %0d", (lastpos.size() < 2) ? -1 : lastpos[1], 261); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_msg();
        test_single_symbol();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef RS_ENC_SHORTEN_EN
        test_shorten();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
